bram_port_arbiter: RTL and testbench

Shares port A of one `xilinx_true_dual_port_read_first_2_clock_ram` instance (HIGH_PERFORMANCE mode) between two requesters: the host `comms` module and the compute engine. The arbiter accepts at most one request per cycle using round-robin arbitration with a burst cap. It registers the winner onto the BRAM port and drives `regcea` at the correct pipeline stage. Read data is returned to the issuing requester in order. One instance sits in front of each of the data, weight and op BRAMs in `top_level`.

---
 rtl/bram_arb_pkg.sv | 32 +++
 rtl/bram_port_arbiter_rr_grant2.sv | 101 ++++++++++
 rtl/bram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Types and constants shared by the BRAM port-A arbiter
//               (bram_port_arbiter) and its round-robin grant unit
//               (rr_grant2).
//                 req_id_t          - requester identity (host comms / engine)
//                 tag_t             - per-request pipeline tag {is_read, id}
//                 BRAM_READ_LATENCY - BRAM cycles from address to douta
//                                     (HIGH_PERFORMANCE: array reg + out reg)
//                 BURST_CNT_WIDTH   - width of the burst counter
//                                     (MAX_BURST <= 255)
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_ENG  = 1'b1
    } req_id_t;

    localparam int BRAM_READ_LATENCY = 2;

    localparam int BURST_CNT_WIDTH = 8;

    typedef struct packed {
        logic    is_read;
        req_id_t id;
    } tag_t;

endpackage : bram_arb_pkg
`default_nettype wire

// File: rtl/bram_port_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant2
// Description : Two-way round-robin grant with a burst cap.
//               Holds the 'last winner' pointer and the burst counter.
//               The grants are combinational from the valids and the state.
//               A grant is only ever raised for a requester whose valid is
//               high. Each grant is also the accept strobe for that cycle.
// Ports       : clk_in          - clock
//               rst_in          - asynchronous reset, active low
//               host_valid_in   - host request present
//               eng_valid_in    - engine request present
//               host_grant_out  - host accepted this cycle
//               eng_grant_out   - engine accepted this cycle
// Parameters  : MAX_BURST       - consecutive grants to one requester while
//                                 the other waits (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2
    import bram_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic host_valid_in,
    input  logic eng_valid_in,
    output logic host_grant_out,
    output logic eng_grant_out
);

    localparam logic [BURST_CNT_WIDTH-1:0] c_max_burst = BURST_CNT_WIDTH'(MAX_BURST);

    req_id_t                    last_q, last_d;
    logic [BURST_CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

    logic    w_keep;
    logic    w_any_grant;
    req_id_t w_winner;
    req_id_t w_other;

    // A zero count means no burst is in progress (out of reset). In that
    // case contention always goes to the requester that is not 'last'.
    // Because 'last' resets to ENG, HOST wins the first contended cycle.
    assign w_keep  = (burst_cnt_q != '0) && (burst_cnt_q < c_max_burst);
    assign w_other = (last_q == REQ_HOST) ? REQ_ENG : REQ_HOST;

    always_comb begin
        host_grant_out = 1'b0;
        eng_grant_out  = 1'b0;
        w_winner       = REQ_HOST;

        // Ready is forced low while reset is held, so all outputs read 0.
        if (rst_in) begin
            if (host_valid_in && eng_valid_in) begin
                w_winner       = w_keep ? last_q : w_other;
                host_grant_out = (w_winner == REQ_HOST);
                eng_grant_out  = (w_winner == REQ_ENG);
            end else begin
                host_grant_out = host_valid_in;
                eng_grant_out  = eng_valid_in;
                w_winner       = eng_valid_in ? REQ_ENG : REQ_HOST;
            end
        end
    end

    assign w_any_grant = host_grant_out | eng_grant_out;

    always_comb begin
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;

        if (w_any_grant) begin
            if (w_winner == last_q) begin
                // Saturate so a long uncontended run cannot wrap the counter.
                // Saturation at the cap also hands the next contended cycle
                // to the other requester.
                if (burst_cnt_q < c_max_burst) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    burst_cnt_d = c_max_burst;
                end
            end else begin
                last_d      = w_winner;
                burst_cnt_d = BURST_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_q      <= REQ_ENG;
            burst_cnt_q <= '0;
        end else begin
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule : rr_grant2
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Shares port A of a read-first true-dual-port BRAM
//               (HIGH_PERFORMANCE, 2-cycle read) between the host comms
//               block and the compute engine. It accepts at most one request
//               per cycle. The winner is registered onto the BRAM port.
//               regcea is driven at the output-register stage. Read data is
//               returned to the issuing requester, in order, with a fixed
//               3-cycle latency.
// Ports       : clk_in, rst_in (async, active low)
//               host_req_* / eng_req_*  - request channels (valid/ready,
//                                         we, addr, write data)
//               host_rsp_* / eng_rsp_*  - read responses (no backpressure)
//               bram_addr_out/din_out/we_out/regce_out -> addra/dina/wea/regcea
//               bram_dout_in            <- douta
// Parameters  : ADDR_WIDTH (14), DATA_WIDTH (64), MAX_BURST (16, 1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    input  logic                  host_req_valid_in,
    output logic                  host_req_ready_out,
    input  logic                  host_req_we_in,
    input  logic [ADDR_WIDTH-1:0] host_req_addr_in,
    input  logic [DATA_WIDTH-1:0] host_req_data_in,
    output logic                  host_rsp_valid_out,
    output logic [DATA_WIDTH-1:0] host_rsp_data_out,

    input  logic                  eng_req_valid_in,
    output logic                  eng_req_ready_out,
    input  logic                  eng_req_we_in,
    input  logic [ADDR_WIDTH-1:0] eng_req_addr_in,
    input  logic [DATA_WIDTH-1:0] eng_req_data_in,
    output logic                  eng_rsp_valid_out,
    output logic [DATA_WIDTH-1:0] eng_rsp_data_out,

    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] bram_din_out,
    output logic                  bram_we_out,
    output logic                  bram_regce_out,
    input  logic [DATA_WIDTH-1:0] bram_dout_in
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_host_grant;
    logic w_eng_grant;

    rr_grant2 #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_grant2 (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .host_valid_in  (host_req_valid_in),
        .eng_valid_in   (eng_req_valid_in),
        .host_grant_out (w_host_grant),
        .eng_grant_out  (w_eng_grant)
    );

    assign host_req_ready_out = w_host_grant;
    assign eng_req_ready_out  = w_eng_grant;

    // ------------------------------------------------------------------
    // Winner mux
    // ------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_acc_we;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_data;

    assign w_accept   = w_host_grant | w_eng_grant;
    assign w_acc_we   = w_eng_grant ? eng_req_we_in   : host_req_we_in;
    assign w_acc_addr = w_eng_grant ? eng_req_addr_in : host_req_addr_in;
    assign w_acc_data = w_eng_grant ? eng_req_data_in : host_req_data_in;

    // ------------------------------------------------------------------
    // Issue register (cycle T+1) and tag pipeline (T+2, T+3)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q,  din_d;
    logic                  we_q,   we_d;
    tag_t                  issue_tag_q, issue_tag_d;

    // Stage 0 lines up with the BRAM output register (regcea).
    // The last stage lines up with douta carrying the word.
    tag_t pipe_q [BRAM_READ_LATENCY];
    tag_t pipe_d [BRAM_READ_LATENCY];

    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        we_d   = 1'b0;

        issue_tag_d.is_read = w_accept & ~w_acc_we;
        issue_tag_d.id      = w_eng_grant ? REQ_ENG : REQ_HOST;

        // Address and data hold when idle. Only wea and the tags are
        // qualified, so the BRAM sees a stable, harmless read otherwise.
        if (w_accept) begin
            addr_d = w_acc_addr;
            din_d  = w_acc_data;
            we_d   = w_acc_we;
        end
    end

    always_comb begin
        pipe_d[0] = issue_tag_q;
        for (int i = 1; i < BRAM_READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            issue_tag_q <= '0;
            for (int i = 0; i < BRAM_READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            issue_tag_q <= issue_tag_d;
            for (int i = 0; i < BRAM_READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    tag_t w_rsp_tag;

    assign w_rsp_tag = pipe_q[BRAM_READ_LATENCY-1];

    assign bram_addr_out  = addr_q;
    assign bram_din_out   = din_q;
    assign bram_we_out    = we_q;
    assign bram_regce_out = pipe_q[0].is_read;

    assign host_rsp_valid_out = w_rsp_tag.is_read & (w_rsp_tag.id == REQ_HOST);
    assign eng_rsp_valid_out  = w_rsp_tag.is_read & (w_rsp_tag.id == REQ_ENG);

    // Both requesters see douta directly. The valid strobes say whose it is.
    assign host_rsp_data_out = bram_dout_in;
    assign eng_rsp_data_out  = bram_dout_in;

endmodule : bram_port_arbiter
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter. Two instances run
//               side by side on shared request inputs: MAX_BURST=4 and
//               MAX_BURST=1. Each instance drives its own read-first,
//               2-stage BRAM model. Expected values come from a
//               transaction-level reference model (arbitration rule, word
//               memory, per-cycle accept history).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int AW      = 6;
    localparam int DW      = 64;
    localparam int DEPTH   = 1 << AW;
    localparam int CYC_MAX = 2200;

    function automatic int burst_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        return {32'hDEAD_BEEF, 32'(a)};
    endfunction

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    logic          hv, hwe, ev, ewe;
    logic [AW-1:0] ha, ea;
    logic [DW-1:0] hd, ed;

    logic [1:0]         h_rdy, e_rdy, h_rv, e_rv, b_we, b_regce;
    logic [1:0][DW-1:0] h_rd, e_rd, b_din, b_dout;
    logic [1:0][AW-1:0] b_addr;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] lat;
        logic [DW-1:0] dout;

        // Read-first port with array register and regce-gated output register
        always @(posedge clk) begin
            if (preload) begin
                for (int a = 0; a < DEPTH; a++) mem[a] <= init_word(a);
                lat  <= '0;
                dout <= '0;
            end else begin
                if (b_we[g]) mem[b_addr[g]] <= b_din[g];
                lat <= mem[b_addr[g]];
                if (b_regce[g]) dout <= lat;
            end
        end

        assign b_dout[g] = dout;

        bram_port_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MAX_BURST  ((g == 0) ? 4 : 1)
        ) u_dut (
            .clk_in             (clk),
            .rst_in             (rst_n),
            .host_req_valid_in  (hv),
            .host_req_ready_out (h_rdy[g]),
            .host_req_we_in     (hwe),
            .host_req_addr_in   (ha),
            .host_req_data_in   (hd),
            .host_rsp_valid_out (h_rv[g]),
            .host_rsp_data_out  (h_rd[g]),
            .eng_req_valid_in   (ev),
            .eng_req_ready_out  (e_rdy[g]),
            .eng_req_we_in      (ewe),
            .eng_req_addr_in    (ea),
            .eng_req_data_in    (ed),
            .eng_rsp_valid_out  (e_rv[g]),
            .eng_rsp_data_out   (e_rd[g]),
            .bram_addr_out      (b_addr[g]),
            .bram_din_out       (b_din[g]),
            .bram_we_out        (b_we[g]),
            .bram_regce_out     (b_regce[g]),
            .bram_dout_in       (b_dout[g])
        );
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int            m_last [2];            // 0 = host, 1 = engine
    int            m_cnt  [2];
    logic [DW-1:0] m_mem  [2][DEPTH];
    bit            pw_valid [2];          // write accepted last cycle
    logic [AW-1:0] pw_addr  [2];
    logic [DW-1:0] pw_data  [2];

    // Per-cycle accept history: kind 0 none, 1 read, 2 write
    int            h_kind [2][CYC_MAX];
    int            h_id   [2][CYC_MAX];
    logic [AW-1:0] h_addr [2][CYC_MAX];
    logic [DW-1:0] h_dat  [2][CYC_MAX];
    bit            h_rst  [CYC_MAX];

    int cyc;
    int n_checks;
    int n_errors;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int kind_at(input int k, input int c);
        return (c < 0) ? 0 : h_kind[k][c];
    endfunction

    function automatic bit rst_at(input int c);
        return (c < 0) ? 1'b0 : h_rst[c];
    endfunction

    // One clock cycle: drive at posedge+1, check and advance model at negedge.
    task automatic step(input bit r_n,
                        input bit hv_i, input bit hwe_i, input logic [AW-1:0] ha_i, input logic [DW-1:0] hd_i,
                        input bit ev_i, input bit ewe_i, input logic [AW-1:0] ea_i, input logic [DW-1:0] ed_i);
        int  win;
        bit  we;
        bit  exp_we, exp_regce, exp_rsp;
        int  c3;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        rst_n = r_n;
        hv = hv_i; hwe = hwe_i; ha = ha_i; hd = hd_i;
        ev = ev_i; ewe = ewe_i; ea = ea_i; ed = ed_i;
        @(negedge clk);
        h_rst[cyc] = !r_n;

        for (int k = 0; k < 2; k++) begin
            // A write lands at the end of the cycle after its accept unless
            // reset intervenes in that cycle.
            if (pw_valid[k] && r_n) m_mem[k][pw_addr[k]] = pw_data[k];
            pw_valid[k] = 1'b0;

            win = -1;
            if (r_n) begin
                if (hv_i && ev_i)
                    win = (m_cnt[k] != 0 && m_cnt[k] < burst_of(k)) ? m_last[k] : 1 - m_last[k];
                else if (hv_i) win = 0;
                else if (ev_i) win = 1;
            end
            chk($sformatf("host_ready[%0d]", k), 64'(h_rdy[k]), 64'(win == 0));
            chk($sformatf("eng_ready[%0d]", k),  64'(e_rdy[k]), 64'(win == 1));

            exp_we    = r_n && kind_at(k, cyc - 1) == 2;
            exp_regce = r_n && !rst_at(cyc - 1) && kind_at(k, cyc - 2) == 1;
            c3        = cyc - 3;
            exp_rsp   = r_n && !rst_at(cyc - 1) && !rst_at(cyc - 2) && kind_at(k, c3) == 1;
            chk($sformatf("bram_we[%0d]", k),    64'(b_we[k]),    64'(exp_we));
            chk($sformatf("bram_regce[%0d]", k), 64'(b_regce[k]), 64'(exp_regce));
            chk($sformatf("host_rsp_valid[%0d]", k), 64'(h_rv[k]), 64'(exp_rsp && h_id[k][c3] == 0));
            chk($sformatf("eng_rsp_valid[%0d]", k),  64'(e_rv[k]), 64'(exp_rsp && h_id[k][c3] == 1));
            if (exp_rsp && h_id[k][c3] == 0) chk($sformatf("host_rsp_data[%0d]", k), h_rd[k], h_dat[k][c3]);
            if (exp_rsp && h_id[k][c3] == 1) chk($sformatf("eng_rsp_data[%0d]", k),  e_rd[k], h_dat[k][c3]);

            if (!r_n) begin
                chk($sformatf("rst_addr[%0d]", k), 64'(b_addr[k]), 64'd0);
                chk($sformatf("rst_din[%0d]", k),  b_din[k],       64'd0);
            end else if (kind_at(k, cyc - 1) != 0) begin
                chk($sformatf("bram_addr[%0d]", k), 64'(b_addr[k]), 64'(h_addr[k][cyc-1]));
                if (exp_we) chk($sformatf("bram_din[%0d]", k), b_din[k], h_dat[k][cyc-1]);
            end

            h_kind[k][cyc] = 0;
            h_id[k][cyc]   = 0;
            if (win >= 0) begin
                if (win == m_last[k]) begin
                    m_cnt[k] = (m_cnt[k] < burst_of(k)) ? m_cnt[k] + 1 : burst_of(k);
                end else begin
                    m_last[k] = win;
                    m_cnt[k]  = 1;
                end
                we   = (win == 0) ? hwe_i : ewe_i;
                addr = (win == 0) ? ha_i  : ea_i;
                data = (win == 0) ? hd_i  : ed_i;
                h_kind[k][cyc] = we ? 2 : 1;
                h_id[k][cyc]   = win;
                h_addr[k][cyc] = addr;
                if (we) begin
                    h_dat[k][cyc] = data;
                    pw_valid[k]   = 1'b1;
                    pw_addr[k]    = addr;
                    pw_data[k]    = data;
                end else begin
                    h_dat[k][cyc] = m_mem[k][addr];
                end
            end
            if (!r_n) begin
                m_last[k] = 1;
                m_cnt[k]  = 0;
            end
        end

        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        hv = 0; hwe = 0; ha = '0; hd = '0;
        ev = 0; ewe = 0; ea = '0; ed = '0;
        for (int k = 0; k < 2; k++) begin
            m_last[k]   = 1;
            m_cnt[k]    = 0;
            pw_valid[k] = 1'b0;
            for (int a = 0; a < DEPTH; a++) m_mem[k][a] = init_word(a);
        end

        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset held with both valids high: everything must read 0
        step(0, 1, 0, 6'd3, 64'd0, 1, 0, 6'd4, 64'd0);
        step(0, 1, 0, 6'd3, 64'd0, 1, 0, 6'd4, 64'd0);

        // Single host read of preloaded address 5
        step(1, 1, 0, 6'd5, 64'd0, 0, 0, 6'd0, 64'd0);
        idle(4);

        // Write then immediate read of the same address
        step(1, 1, 1, 6'd7, 64'h1234, 0, 0, 6'd0, 64'd0);
        step(1, 1, 0, 6'd7, 64'd0,    0, 0, 6'd0, 64'd0);
        idle(4);

        // Host read then engine read in consecutive cycles
        step(1, 1, 0, 6'd1, 64'd0, 0, 0, 6'd0, 64'd0);
        step(1, 0, 0, 6'd0, 64'd0, 1, 0, 6'd2, 64'd0);
        idle(4);

        // Burst cap: engine alone for 3 cycles, then both contend
        for (int i = 0; i < 3; i++) step(1, 0, 0, 6'd0, 64'd0, 1, 0, 6'(10 + i), 64'd0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 6'(20 + i), 64'd0, 1, 0, 6'(30 + i), 64'd0);
        idle(4);

        // Reset arriving one cycle after a read accept, then both contend
        step(1, 1, 0, 6'd5, 64'd0, 0, 0, 6'd0, 64'd0);
        step(0, 0, 0, 6'd0, 64'd0, 0, 0, 6'd0, 64'd0);
        step(0, 1, 0, 6'd0, 64'd0, 1, 0, 6'd0, 64'd0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 6'(i), 64'd0, 1, 0, 6'(40 + i), 64'd0);
        idle(4);

        // Randomized mix on a small address window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 6'($urandom_range(0, 11)), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 6'($urandom_range(0, 11)), {$urandom, $urandom});
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bram_port_arbiter
`default_nettype wire
